// File: rtl/stack_cpu_core.sv
// stack_cpu_core: parametrised stack-machine core. Program words come from a ROM and the
// operand stack lives in data RAM; both memories have a read latency of MEM_LAT cycles.
// Optional feature: define STACK_CPU_MUL_EN to enable the MUL opcode (0x2002).
module stack_cpu_core #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned MEM_LAT     = 2,
   parameter int unsigned STACK_BASE  = 0,
   parameter int unsigned STACK_DEPTH = 256
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] address_rom,
   input  logic [DATA_W-1:0] q_rom,
   output logic [ADDR_W-1:0] address_ram,
   input  logic [DATA_W-1:0] q_ram,
   output logic [DATA_W-1:0] data_ram,
   output logic              wren_ram,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] sp_o,
   output logic [3:0]        state_o,
   output logic              halted,
   output logic              error,
   output logic [1:0]        err_code
);

   localparam logic [15:0] OpNop = 16'h0000, OpImm = 16'h0002, OpCp   = 16'h0007;
   localparam logic [15:0] OpHalt = 16'h00ff, OpJmp = 16'h1000, OpBra = 16'h1001;
   localparam logic [15:0] OpAdd = 16'h2000, OpSub = 16'h2001, OpMul  = 16'h2002;
   localparam logic [15:0] OpGret = 16'h2005, OpLess = 16'h2006, OpEq = 16'h2007;
   localparam logic [15:0] OpNeq = 16'h2008, OpAnd = 16'h2009, OpOr  = 16'h200a;
   localparam logic [15:0] OpXor = 16'h200b, OpNot = 16'h200c;

   localparam logic [ADDR_W-1:0] Base  = ADDR_W'(STACK_BASE);
   localparam logic [ADDR_W-1:0] Depth = ADDR_W'(STACK_DEPTH);
   localparam logic [ADDR_W-1:0] One   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] Two   = ADDR_W'(2);
   localparam logic [2:0]        Lat   = 3'(MEM_LAT);
   localparam logic [2:0]        LatM1 = 3'(MEM_LAT - 1);

   typedef enum logic [3:0] {
      StFetch = 4'd0, StDecode = 4'd1, StOperWait = 4'd2, StRdA = 4'd3, StRdB = 4'd4,
      StExec = 4'd5, StWrite = 4'd6, StHalt = 4'd7, StError = 4'd8
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, sp_q, sp_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [15:0]       op_q, op_d;
   logic [DATA_W-1:0] opnd_q, opnd_d, a_q, a_d, b_q, b_d;
   logic [1:0]        ec_q, ec_d;

   logic [15:0]       op_in;
   logic              hi_zero;
   logic [1:0]        pops;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] wr_idx;

   function automatic logic is_binary(input logic [15:0] op);
      case (op)
         OpAdd, OpSub, OpGret, OpLess, OpEq, OpNeq, OpAnd, OpOr, OpXor: is_binary = 1'b1;
`ifdef STACK_CPU_MUL_EN
         OpMul: is_binary = 1'b1;
`endif
         default: is_binary = 1'b0;
      endcase
   endfunction

   function automatic logic is_legal(input logic [15:0] op);
      case (op)
         OpNop, OpImm, OpCp, OpHalt, OpJmp, OpBra, OpNot: is_legal = 1'b1;
         default: is_legal = is_binary(op);
      endcase
   endfunction

   assign op_in   = q_rom[15:0];
   assign hi_zero = ((q_rom >> 16) == '0);

   // Number of stack entries the fetched opcode consumes (underflow check)
   always_comb begin
      pops = 2'd0;
      if (is_binary(op_in) || op_in == OpBra) pops = 2'd2;
      else if (op_in == OpCp || op_in == OpNot) pops = 2'd1;
   end

   // State register; reset aborts any instruction in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
         pc_q    <= '0;
         sp_q    <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
         opnd_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ec_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ec_q    <= ec_d;
      end
   end

   // Next-state logic: wait states count memory latency, traps freeze pc/sp
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      a_d     = a_q;
      b_d     = b_q;
      ec_d    = ec_q;
      unique case (state_q)
         StFetch: begin
            if (cnt_q == LatM1) begin
               cnt_d   = '0;
               state_d = StDecode;
            end else cnt_d = cnt_q + 3'd1;
         end
         StDecode: begin
            op_d = op_in;
            if (!hi_zero || !is_legal(op_in)) begin
               ec_d    = 2'd1;
               state_d = StError;
            end else if (sp_q < ADDR_W'(pops)) begin
               ec_d    = 2'd2;
               state_d = StError;
            end else if ((op_in == OpImm || op_in == OpCp) && sp_q == Depth) begin
               ec_d    = 2'd3;
               state_d = StError;
            end else if (op_in == OpHalt) begin
               state_d = StHalt;
            end else if (op_in == OpImm || op_in == OpJmp) begin
               pc_d    = pc_q + One;
               state_d = StOperWait;
            end else if (pops != 2'd0) begin
               state_d = StRdA;
            end else begin
               state_d = StExec;
            end
         end
         StOperWait: begin
            if (cnt_q == Lat) begin
               opnd_d  = q_rom;
               cnt_d   = '0;
               state_d = (op_q == OpImm) ? StWrite : StExec;
            end else cnt_d = cnt_q + 3'd1;
         end
         StRdA: begin
            // Two-operand ops overlap: TOS data is latched in the first RD_B cycle
            if (is_binary(op_q) || op_q == OpBra) begin
               if (cnt_q == LatM1) begin
                  cnt_d   = '0;
                  state_d = StRdB;
               end else cnt_d = cnt_q + 3'd1;
            end else if (cnt_q == Lat) begin
               a_d     = q_ram;
               cnt_d   = '0;
               state_d = StWrite;
            end else cnt_d = cnt_q + 3'd1;
         end
         StRdB: begin
            if (cnt_q == 3'd0) a_d = q_ram;
            if (cnt_q == Lat) begin
               b_d     = q_ram;
               cnt_d   = '0;
               state_d = (op_q == OpBra) ? StExec : StWrite;
            end else cnt_d = cnt_q + 3'd1;
         end
         StExec: begin
            state_d = StFetch;
            if (op_q == OpJmp) begin
               pc_d = ADDR_W'(opnd_q);
            end else if (op_q == OpBra) begin
               sp_d = sp_q - Two;
               pc_d = (a_q != '0) ? ADDR_W'(b_q) : pc_q + One;
            end else begin
               pc_d = pc_q + One;
            end
         end
         StWrite: begin
            state_d = StFetch;
            pc_d    = pc_q + One;
            if (op_q == OpImm || op_q == OpCp) sp_d = sp_q + One;
            else if (op_q != OpNot) sp_d = sp_q - One;
         end
         StHalt, StError: ;
         default: state_d = StFetch;
      endcase
   end

   // Result and target slot for the WRITE cycle
   always_comb begin
      wr_data = '0;
      wr_idx  = sp_q - Two;
      case (op_q)
         OpImm:  begin wr_data = opnd_q; wr_idx = sp_q; end
         OpCp:   begin wr_data = a_q;    wr_idx = sp_q; end
         OpNot:  begin wr_data = ~a_q;   wr_idx = sp_q - One; end
         OpAdd:  wr_data = b_q + a_q;
         OpSub:  wr_data = b_q - a_q;
`ifdef STACK_CPU_MUL_EN
         OpMul:  wr_data = b_q * a_q;
`endif
         OpGret: wr_data = DATA_W'(b_q > a_q);
         OpLess: wr_data = DATA_W'(b_q < a_q);
         OpEq:   wr_data = DATA_W'(b_q == a_q);
         OpNeq:  wr_data = DATA_W'(b_q != a_q);
         OpAnd:  wr_data = b_q & a_q;
         OpOr:   wr_data = b_q | a_q;
         OpXor:  wr_data = b_q ^ a_q;
         default: ;
      endcase
   end

   // RAM port: read addresses during operand reads, write strobe only in WRITE
   always_comb begin
      address_ram = '0;
      data_ram    = '0;
      wren_ram    = 1'b0;
      unique case (state_q)
         StRdA:   address_ram = Base + sp_q - One;
         StRdB:   address_ram = Base + sp_q - Two;
         StWrite: begin
            address_ram = Base + wr_idx;
            data_ram    = wr_data;
            wren_ram    = 1'b1;
         end
         default: ;
      endcase
   end

   assign address_rom = pc_q;
   assign pc_o        = pc_q;
   assign sp_o        = sp_q;
   assign state_o     = state_q;
   assign halted      = (state_q == StHalt);
   assign error       = (state_q == StError);
   assign err_code    = ec_q;

endmodule

// File: tb/tb_stack_cpu_core.sv
// tb_stack_cpu_core: scoreboard bench. Four cores (different latency/depth/base) share one
// program ROM; only the selected core is out of reset. Expected RAM writes and per-instruction
// cycle counts are queued by the stimulus and consumed by a separate monitor process.
module tb_stack_cpu_core;

   localparam int NI = 4;
   localparam int LATS   [NI] = '{2, 1, 4, 2};
   localparam int DEPTHS [NI] = '{256, 256, 256, 2};
   localparam int BASES  [NI] = '{0, 0, 0, 16};

   localparam logic [15:0] OpNop = 16'h0000, OpImm = 16'h0002, OpCp = 16'h0007;
   localparam logic [15:0] OpHalt = 16'h00ff, OpJmp = 16'h1000, OpBra = 16'h1001;
   localparam logic [15:0] OpAdd = 16'h2000, OpSub = 16'h2001, OpMul = 16'h2002;
   localparam logic [15:0] OpGret = 16'h2005, OpLess = 16'h2006, OpEq = 16'h2007;
   localparam logic [15:0] OpNeq = 16'h2008, OpAnd = 16'h2009, OpOr = 16'h200a;
   localparam logic [15:0] OpXor = 16'h200b, OpNot = 16'h200c;

   logic clock = 1'b0;
   logic [NI-1:0] rst = '1;
   int sel = 0;
   int checks = 0;
   int errors = 0;
   int wr_count = 0;

   logic [15:0] rom [0:63];
   logic [15:0] prog [$];
   logic [31:0] exp_wr [$];
   int          exp_len [$];

   logic [NI-1:0]       mon_wr, mon_halt, mon_err;
   logic [NI-1:0][15:0] mon_aram, mon_dram, mon_pc, mon_sp;
   logic [NI-1:0][3:0]  mon_st;
   logic [NI-1:0][1:0]  mon_ec;

   always #5 clock = ~clock;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = LATS[g];
      logic [15:0] arom, qr, aram, qm, dram, pco, spo;
      logic        wr, hl, er;
      logic [3:0]  st;
      logic [1:0]  ec;
      logic [15:0] rpipe [L];
      logic [15:0] mpipe [L];
      logic [15:0] ram [0:63];

      stack_cpu_core #(
         .DATA_W(16), .ADDR_W(16), .MEM_LAT(L), .STACK_BASE(BASES[g]), .STACK_DEPTH(DEPTHS[g])
      ) u_dut (
         .clock(clock), .reset(rst[g]), .address_rom(arom), .q_rom(qr), .address_ram(aram),
         .q_ram(qm), .data_ram(dram), .wren_ram(wr), .pc_o(pco), .sp_o(spo), .state_o(st),
         .halted(hl), .error(er), .err_code(ec)
      );

      // L-cycle read pipelines for ROM and RAM, RAM write on the strobe
      always @(posedge clock) begin
         rpipe[0] <= arom;
         mpipe[0] <= aram;
         for (int i = 1; i < L; i++) begin
            rpipe[i] <= rpipe[i-1];
            mpipe[i] <= mpipe[i-1];
         end
         if (wr) ram[aram[5:0]] <= dram;
      end

      assign qr = rom[rpipe[L-1][5:0]];
      assign qm = ram[mpipe[L-1][5:0]];
      assign mon_wr[g]   = wr;
      assign mon_halt[g] = hl;
      assign mon_err[g]  = er;
      assign mon_aram[g] = aram;
      assign mon_dram[g] = dram;
      assign mon_pc[g]   = pco;
      assign mon_sp[g]   = spo;
      assign mon_st[g]   = st;
      assign mon_ec[g]   = ec;
   end

   // Monitor: checks every RAM write and the length of every completed instruction
   initial begin : monitor
      logic [3:0]  prev_st;
      logic [31:0] e;
      bit          seen;
      int          start, cyc, need;
      prev_st = '0;
      seen = 0;
      start = 0;
      cyc = 0;
      forever begin
         @(negedge clock);
         cyc++;
         if (rst[sel]) begin
            seen = 0;
            prev_st = '0;
            wr_count = 0;
         end else begin
            if (mon_wr[sel]) begin
               wr_count++;
               checks++;
               if (exp_wr.size() == 0) begin
                  errors++;
                  $display("FAIL write: unexpected addr %h data %h", mon_aram[sel], mon_dram[sel]);
               end else begin
                  e = exp_wr.pop_front();
                  if (mon_aram[sel] !== e[31:16] || mon_dram[sel] !== e[15:0]) begin
                     errors++;
                     $display("FAIL write: got addr %h data %h, need addr %h data %h",
                              mon_aram[sel], mon_dram[sel], e[31:16], e[15:0]);
                  end
               end
            end
            if (mon_st[sel] == 4'd0 && (prev_st != 4'd0 || !seen)) begin
               if (seen) begin
                  checks++;
                  if (exp_len.size() == 0) begin
                     errors++;
                     $display("FAIL cycles: unexpected instruction of %0d cycles", cyc - start);
                  end else begin
                     need = exp_len.pop_front();
                     if (cyc - start != need) begin
                        errors++;
                        $display("FAIL cycles: got %0d, need %0d", cyc - start, need);
                     end
                  end
               end
               seen = 1;
               start = cyc;
            end
            prev_st = mon_st[sel];
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), need %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < 64; i++) rom[i] = 16'hffff;
      for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
   endtask

   task automatic push_wr(input int addr, input int data);
      exp_wr.push_back({addr[15:0], data[15:0]});
   endtask

   task automatic push_len(input int n);
      exp_len.push_back(n);
   endtask

   // Release core g, wait for HALT/ERROR, compare the final architectural state
   task automatic run_prog(input int g, input int h_exp, input int ec_exp, input int pc_exp,
                           input int sp_exp, input int nwr);
      int n;
      sel = g;
      @(posedge clock);
      #1 rst[g] = 1'b0;
      n = 0;
      while (!mon_halt[g] && !mon_err[g] && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check("terminated in budget", int'(n < 2000), 1);
      @(negedge clock);
      check("halted", int'(mon_halt[g]), h_exp);
      check("error", int'(mon_err[g]), int'(ec_exp != 0));
      check("err_code", int'(mon_ec[g]), ec_exp);
      check("pc", int'(mon_pc[g]), pc_exp);
      check("sp", int'(mon_sp[g]), sp_exp);
      check("write count", wr_count, nwr);
      check("writes pending", exp_wr.size(), 0);
      check("instr pending", exp_len.size(), 0);
      rst[g] = 1'b1;
      exp_wr.delete();
      exp_len.delete();
      @(negedge clock);
   endtask

   task automatic t_add(input int g, input int lat);
      prog = '{OpImm, 16'd3, OpImm, 16'd5, OpAdd, OpHalt};
      load_prog();
      push_wr(0, 3); push_wr(1, 5); push_wr(0, 8);
      push_len(2*lat+3); push_len(2*lat+3); push_len(3*lat+3);
      run_prog(g, 1, 0, 5, 1, 3);
   endtask

   task automatic t_mix(input int g, input int lat);
      int i, u, b;
      i = 2*lat+3; u = 2*lat+3; b = 3*lat+3;
      prog = '{OpImm, 16'h00f0, OpNot, OpCp, OpEq, OpImm, 16'd2, OpLess, OpImm, 16'd3, OpGret,
               OpImm, 16'd0, OpNeq, OpImm, 16'h00ff, OpOr, OpImm, 16'h0f0f, OpAnd, OpNop,
               OpJmp, 16'd24, 16'hffff, OpHalt};
      load_prog();
      push_wr(0, 'h00f0); push_wr(0, 'hff0f); push_wr(1, 'hff0f); push_wr(0, 1);
      push_wr(1, 2); push_wr(0, 1); push_wr(1, 3); push_wr(0, 0); push_wr(1, 0);
      push_wr(0, 0); push_wr(1, 'h00ff); push_wr(0, 'h00ff); push_wr(1, 'h0f0f);
      push_wr(0, 'h000f);
      push_len(i); push_len(u); push_len(u); push_len(b); push_len(i); push_len(b);
      push_len(i); push_len(b); push_len(i); push_len(b); push_len(i); push_len(b);
      push_len(i); push_len(b); push_len(lat+2); push_len(2*lat+3);
      run_prog(g, 1, 0, 24, 1, 14);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clock);

      t_add(0, 2);

      prog = '{OpImm, 16'd7, OpImm, 16'd2, OpSub, OpImm, 16'd6, OpImm, 16'd3, OpXor, OpHalt};
      load_prog();
      push_wr(0, 7); push_wr(1, 2); push_wr(0, 5); push_wr(1, 6); push_wr(2, 3); push_wr(1, 5);
      push_len(7); push_len(7); push_len(9); push_len(7); push_len(7); push_len(9);
      run_prog(0, 1, 0, 10, 2, 6);

      // Taken branch: target 9 (NOS), cond 1 (TOS)
      prog = '{OpImm, 16'd9, OpImm, 16'd1, OpBra, 16'hffff, 16'hffff, 16'hffff, 16'hffff,
               OpHalt};
      load_prog();
      push_wr(0, 9); push_wr(1, 1);
      push_len(7); push_len(7); push_len(9);
      run_prog(0, 1, 0, 9, 0, 2);

      // Not taken: falls through to pc 5
      prog = '{OpImm, 16'd9, OpImm, 16'd0, OpBra, OpHalt};
      load_prog();
      push_wr(0, 9); push_wr(1, 0);
      push_len(7); push_len(7); push_len(9);
      run_prog(0, 1, 0, 5, 0, 2);

      prog = '{OpAdd, OpHalt};
      load_prog();
      run_prog(0, 0, 2, 0, 0, 0);

      prog = '{16'h1234, OpHalt};
      load_prog();
      run_prog(0, 0, 1, 0, 0, 0);

      prog = '{OpImm, 16'd3, OpImm, 16'd4, OpMul, OpHalt};
      load_prog();
      push_wr(0, 3); push_wr(1, 4);
      push_len(7); push_len(7);
`ifdef STACK_CPU_MUL_EN
      push_wr(0, 12); push_len(9);
      run_prog(0, 1, 0, 5, 1, 3);
`else
      run_prog(0, 0, 1, 4, 2, 2);
`endif

      t_mix(0, 2);

      // Depth-2 stack at base 16: third push overflows
      prog = '{OpImm, 16'd1, OpImm, 16'd2, OpImm, 16'd3, OpHalt};
      load_prog();
      push_wr(16, 1); push_wr(17, 2);
      push_len(7); push_len(7);
      run_prog(3, 0, 3, 4, 2, 2);

      // Reset asserted during RD_B of ADD aborts it with no write
      prog = '{OpImm, 16'd3, OpImm, 16'd5, OpAdd, OpHalt};
      load_prog();
      push_wr(0, 3); push_wr(1, 5);
      push_len(7); push_len(7);
      sel = 0;
      @(posedge clock);
      #1 rst[0] = 1'b0;
      n = 0;
      while (mon_st[0] != 4'd4 && n < 200) begin
         @(posedge clock);
         #1 n++;
      end
      check("reached RD_B", int'(mon_st[0]), 4);
      check("sp before reset", int'(mon_sp[0]), 2);
      rst[0] = 1'b1;
      #1;
      check("reset state", int'(mon_st[0]), 0);
      check("reset pc", int'(mon_pc[0]), 0);
      check("reset sp", int'(mon_sp[0]), 0);
      check("reset wren", int'(mon_wr[0]), 0);
      check("reset address_ram", int'(mon_aram[0]), 0);
      check("reset data_ram", int'(mon_dram[0]), 0);
      check("reset halted", int'(mon_halt[0]), 0);
      check("reset error", int'(mon_err[0]), 0);
      check("reset err_code", int'(mon_ec[0]), 0);
      repeat (4) @(negedge clock);
      check("reset wren later", int'(mon_wr[0]), 0);
      check("reset writes pending", exp_wr.size(), 0);
      check("reset instr pending", exp_len.size(), 0);
      exp_wr.delete();
      exp_len.delete();

      t_add(1, 1);
      t_mix(1, 1);
      t_add(2, 4);
      t_mix(2, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
